// File: rtl/conv2d_stream.sv
// conv2d_stream: sequential 2-D convolution (cross-correlation) engine.
//
// Buffers one multi-channel input frame from a valid/ready stream. Each output
// element is then built with one multiply-accumulate per cycle over all input
// channels and kernel taps, starting from the per-output-channel bias. The sum
// is arithmetically right-shifted by frac_bits, saturated to data_size bits and
// emitted on a valid/ready stream.
//
// Optional build macro: CONV2D_STREAM_RELU_EN
//   defined   -> negative saturated results are clamped to 0
//   undefined -> signed saturated result passes unchanged
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   wgt_we/wgt_addr/wgt_data     weight write (IDLE only), index
//                                ((co*in_channels+ci)*kernel_rows+kr)*kernel_cols+kc
//   bias_we/bias_addr/bias_data  bias write per output channel (IDLE only)
//   start                        begin a frame (IDLE only)
//   busy                         high outside IDLE
//   done                         one-cycle pulse after the last output is accepted
//   in_valid/in_ready/in_data    pixel stream, ci-major, then row, then col
//   out_valid/out_ready/out_data result stream, co-major, then out row, then out col
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; weight/bias writes accepted
// LOAD   | storing in_channels*rows*cols input pixels
// MAC    | one multiply-accumulate per cycle for the current output
// FIN    | shift, saturate (and optional relu), register result
// EMIT   | holding result until the consumer accepts it

module conv2d_stream #(
    parameter int in_channels  = 1,
    parameter int out_channels = 1,
    parameter int kernel_rows  = 3,
    parameter int kernel_cols  = 3,
    parameter int stride_row   = 1,
    parameter int stride_col   = 1,
    parameter int pad_rows     = 0,
    parameter int pad_cols     = 0,
    parameter int rows         = 27,
    parameter int cols         = 27,
    parameter int data_size    = 8,
    parameter int acc_size     = 32,
    parameter int frac_bits    = 0,
    localparam int N_WGT   = out_channels * in_channels * kernel_rows * kernel_cols,
    localparam int WGT_AW  = (N_WGT > 1) ? $clog2(N_WGT) : 1,
    localparam int BIAS_AW = (out_channels > 1) ? $clog2(out_channels) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wgt_we,
    input  logic [WGT_AW-1:0]           wgt_addr,
    input  logic signed [data_size-1:0] wgt_data,
    input  logic                        bias_we,
    input  logic [BIAS_AW-1:0]          bias_addr,
    input  logic signed [data_size-1:0] bias_data,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [data_size-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [data_size-1:0] out_data
);

    localparam int OUT_ROWS = (rows + 2 * pad_rows - kernel_rows) / stride_row + 1;
    localparam int OUT_COLS = (cols + 2 * pad_cols - kernel_cols) / stride_col + 1;
    localparam int N_PIX    = in_channels * rows * cols;
    localparam int K_TAPS   = in_channels * kernel_rows * kernel_cols;

    localparam int PIX_AW = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam int ORW_W  = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam int OCW_W  = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam int CI_W   = (in_channels > 1) ? $clog2(in_channels) : 1;
    localparam int KR_W   = (kernel_rows > 1) ? $clog2(kernel_rows) : 1;
    localparam int KC_W   = (kernel_cols > 1) ? $clog2(kernel_cols) : 1;
    localparam int MAC_W  = (K_TAPS > 1) ? $clog2(K_TAPS) : 1;

    localparam logic [PIX_AW-1:0]  PIX_LAST  = PIX_AW'(N_PIX - 1);
    localparam logic [BIAS_AW-1:0] CO_LAST   = BIAS_AW'(out_channels - 1);
    localparam logic [ORW_W-1:0]   OROW_LAST = ORW_W'(OUT_ROWS - 1);
    localparam logic [OCW_W-1:0]   OCOL_LAST = OCW_W'(OUT_COLS - 1);
    localparam logic [CI_W-1:0]    CI_LAST   = CI_W'(in_channels - 1);
    localparam logic [KR_W-1:0]    KR_LAST   = KR_W'(kernel_rows - 1);
    localparam logic [KC_W-1:0]    KC_LAST   = KC_W'(kernel_cols - 1);
    localparam logic [MAC_W-1:0]   MAC_LAST  = MAC_W'(K_TAPS - 1);

    localparam logic signed [acc_size-1:0] SAT_MAX =
        {{(acc_size - data_size + 1){1'b0}}, {(data_size - 1){1'b1}}};
    localparam logic signed [acc_size-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_FIN,
        S_EMIT
    } state_t;

    state_t state_q, state_d;

    logic signed [data_size-1:0] pix_mem  [N_PIX];
    logic signed [data_size-1:0] wgt_mem  [N_WGT];
    logic signed [data_size-1:0] bias_mem [out_channels];

    logic [PIX_AW-1:0]  pix_cnt;
    logic [BIAS_AW-1:0] co;
    logic [ORW_W-1:0]   orow;
    logic [OCW_W-1:0]   ocol;
    logic [CI_W-1:0]    ci;
    logic [KR_W-1:0]    kr;
    logic [KC_W-1:0]    kc;
    logic [MAC_W-1:0]   mac_cnt;
    logic signed [acc_size-1:0] acc;

    // combinational datapath
    int                          row_i, col_i, pix_i, wgt_i;
    logic                        in_bounds;
    logic [PIX_AW-1:0]           pix_idx;
    logic [WGT_AW-1:0]           wgt_idx;
    logic signed [data_size-1:0] x_val, w_val;
    logic signed [2*data_size-1:0] prod;
    logic signed [acc_size-1:0]  prod_ext;
    logic signed [acc_size-1:0]  acc_init;
    logic signed [acc_size-1:0]  shifted;
    logic signed [data_size-1:0] sat_res, res;
    logic [BIAS_AW-1:0]          co_nx, bias_sel;
    logic [ORW_W-1:0]            orow_nx;
    logic [OCW_W-1:0]            ocol_nx;
    logic                        out_last;
    logic                        pix_last;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && pix_last) state_d = S_MAC;
            end
            S_MAC: begin
                if (mac_cnt == '0) state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) state_d = out_last ? S_IDLE : S_MAC;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output position stepping and tap addressing
    // ------------------------------------------------------------------
    always_comb begin
        pix_last = (pix_cnt == PIX_LAST);
        out_last = (co == CO_LAST) && (orow == OROW_LAST) && (ocol == OCOL_LAST);

        ocol_nx = (ocol == OCOL_LAST) ? '0 : ocol + 1'b1;
        orow_nx = orow;
        co_nx   = co;
        if (ocol == OCOL_LAST) begin
            orow_nx = (orow == OROW_LAST) ? '0 : orow + 1'b1;
            if (orow == OROW_LAST) co_nx = (co == CO_LAST) ? '0 : co + 1'b1;
        end

        // Bias for the output about to start: the stepped channel when
        // leaving EMIT, the current (zero) channel when leaving LOAD.
        bias_sel = (state_q == S_EMIT) ? co_nx : co;
        acc_init = acc_size'(bias_mem[bias_sel]) <<< frac_bits;

        row_i = int'(orow) * stride_row + int'(kr) - pad_rows;
        col_i = int'(ocol) * stride_col + int'(kc) - pad_cols;
        in_bounds = (row_i >= 0) && (row_i < rows) && (col_i >= 0) && (col_i < cols);
        pix_i = (int'(ci) * rows + row_i) * cols + col_i;
        wgt_i = ((int'(co) * in_channels + int'(ci)) * kernel_rows + int'(kr)) * kernel_cols
                + int'(kc);
        pix_idx = in_bounds ? PIX_AW'(pix_i) : '0;
        wgt_idx = WGT_AW'(wgt_i);

        x_val    = in_bounds ? pix_mem[pix_idx] : '0;
        w_val    = wgt_mem[wgt_idx];
        prod     = x_val * w_val;
        prod_ext = acc_size'(prod);

        shifted = acc >>> frac_bits;
        if (shifted > SAT_MAX)      sat_res = SAT_MAX[data_size-1:0];
        else if (shifted < SAT_MIN) sat_res = SAT_MIN[data_size-1:0];
        else                        sat_res = shifted[data_size-1:0];
`ifdef CONV2D_STREAM_RELU_EN
        res = sat_res[data_size-1] ? '0 : sat_res;
`else
        res = sat_res;
`endif
    end

    // ------------------------------------------------------------------
    // Memories (not cleared by reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wgt_we && state_q == S_IDLE && int'(wgt_addr) < N_WGT)
            wgt_mem[wgt_addr] <= wgt_data;
        if (bias_we && state_q == S_IDLE && int'(bias_addr) < out_channels)
            bias_mem[bias_addr] <= bias_data;
        if (state_q == S_LOAD && in_valid)
            pix_mem[pix_cnt] <= in_data;
    end

    // ------------------------------------------------------------------
    // Counters, accumulator and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt   <= '0;
            co        <= '0;
            orow      <= '0;
            ocol      <= '0;
            ci        <= '0;
            kr        <= '0;
            kc        <= '0;
            mac_cnt   <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
                        if (pix_last) begin
                            acc     <= acc_init;
                            ci      <= '0;
                            kr      <= '0;
                            kc      <= '0;
                            mac_cnt <= MAC_LAST;
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc + prod_ext;
                    if (mac_cnt != '0) mac_cnt <= mac_cnt - 1'b1;
                    if (kc == KC_LAST) begin
                        kc <= '0;
                        if (kr == KR_LAST) begin
                            kr <= '0;
                            ci <= (ci == CI_LAST) ? '0 : ci + 1'b1;
                        end else begin
                            kr <= kr + 1'b1;
                        end
                    end else begin
                        kc <= kc + 1'b1;
                    end
                end
                S_FIN: begin
                    out_data  <= res;
                    out_valid <= 1'b1;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        co        <= co_nx;
                        orow      <= orow_nx;
                        ocol      <= ocol_nx;
                        if (out_last) begin
                            done <= 1'b1;
                        end else begin
                            acc     <= acc_init;
                            ci      <= '0;
                            kr      <= '0;
                            kc      <= '0;
                            mac_cnt <= MAC_LAST;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream. Three instances with different geometry
// share the stimulus buses; sel picks which one a task talks to.
//   0: 1x1 kernel, 4x4 input
//   1: 2x2 kernel, stride 2, 4x4 input
//   2: 3x3 kernel, pad 1, 3x3 input

module tb_conv2d_stream;

    logic               clk;
    logic               rst;
    logic signed [7:0]  wgt_data;
    logic [3:0]         wgt_addr;
    logic signed [7:0]  bias_data;
    logic               bias_addr;
    logic               in_valid;
    logic signed [7:0]  in_data;
    logic               out_ready;

    logic [2:0]         start_v, wgt_we_v, bias_we_v;
    logic [2:0]         busy_v, done_v, in_ready_v, out_valid_v;
    logic signed [7:0]  out_data_v [3];

    int                 sel;
    logic               busy_m, done_m, in_ready_m, out_valid_m;
    logic signed [7:0]  out_data_m;

    int                 checks;
    int                 errors;
    int                 pix_buf [16];
    int                 exp_buf [16];

    assign busy_m      = busy_v[sel];
    assign done_m      = done_v[sel];
    assign in_ready_m  = in_ready_v[sel];
    assign out_valid_m = out_valid_v[sel];
    assign out_data_m  = out_data_v[sel];

    conv2d_stream #(
        .kernel_rows(1), .kernel_cols(1), .rows(4), .cols(4)
    ) dut_a (
        .clk(clk), .rst(rst),
        .wgt_we(wgt_we_v[0]), .wgt_addr(wgt_addr[0:0]), .wgt_data(wgt_data),
        .bias_we(bias_we_v[0]), .bias_addr(bias_addr), .bias_data(bias_data),
        .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .in_valid(in_valid), .in_ready(in_ready_v[0]), .in_data(in_data),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0])
    );

    conv2d_stream #(
        .kernel_rows(2), .kernel_cols(2), .stride_row(2), .stride_col(2),
        .rows(4), .cols(4)
    ) dut_b (
        .clk(clk), .rst(rst),
        .wgt_we(wgt_we_v[1]), .wgt_addr(wgt_addr[1:0]), .wgt_data(wgt_data),
        .bias_we(bias_we_v[1]), .bias_addr(bias_addr), .bias_data(bias_data),
        .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .in_valid(in_valid), .in_ready(in_ready_v[1]), .in_data(in_data),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1])
    );

    conv2d_stream #(
        .kernel_rows(3), .kernel_cols(3), .pad_rows(1), .pad_cols(1),
        .rows(3), .cols(3)
    ) dut_c (
        .clk(clk), .rst(rst),
        .wgt_we(wgt_we_v[2]), .wgt_addr(wgt_addr[3:0]), .wgt_data(wgt_data),
        .bias_we(bias_we_v[2]), .bias_addr(bias_addr), .bias_data(bias_data),
        .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .in_valid(in_valid), .in_ready(in_ready_v[2]), .in_data(in_data),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_data(out_data_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic write_wgt(input int s, input int a, input int v);
        sel = s;
        @(negedge clk);
        wgt_addr    = 4'(a);
        wgt_data    = 8'(v);
        wgt_we_v[s] = 1'b1;
        @(negedge clk);
        wgt_we_v[s] = 1'b0;
    endtask

    task automatic write_bias(input int s, input int v);
        sel = s;
        @(negedge clk);
        bias_addr    = 1'b0;
        bias_data    = 8'(v);
        bias_we_v[s] = 1'b1;
        @(negedge clk);
        bias_we_v[s] = 1'b0;
    endtask

    task automatic start_frame(input int s);
        sel = s;
        @(negedge clk);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
    endtask

    task automatic feed(input int n_pix, input bit gapped, input string name);
        int i, cyc;
        bit hs;
        i = 0;
        cyc = 0;
        while (i < n_pix && cyc < 1000) begin
            in_valid = !(gapped && $urandom_range(0, 2) == 0);
            in_data  = 8'(pix_buf[i]);
            hs = in_valid && in_ready_m;
            @(negedge clk);
            cyc++;
            if (hs) i++;
        end
        in_valid = 1'b0;
        check_val({name, "_loaded"}, i, n_pix);
    endtask

    task automatic run_frame(input int s, input int n_pix, input int n_out,
                             input bit gapped, input string name);
        int idx, cyc, done_cnt;
        bit rdy;
        start_frame(s);
        check_val({name, "_busy"}, int'(busy_m), 1);
        feed(n_pix, gapped, name);
        idx = 0;
        cyc = 0;
        done_cnt = 0;
        while (idx < n_out && cyc < 2000) begin
            rdy = gapped ? (cyc % 3 == 0) : 1'b1;
            out_ready = rdy;
            if (done_m) done_cnt++;
            if (out_valid_m) begin
                // repeated while stalled: output must hold its value
                check_val($sformatf("%s_out%0d", name, idx), int'(out_data_m), exp_buf[idx]);
                if (rdy) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check_val({name, "_count"}, idx, n_out);
        repeat (3) begin
            if (done_m) done_cnt++;
            @(negedge clk);
        end
        check_val({name, "_done_pulses"}, done_cnt, 1);
        check_val({name, "_idle"}, int'(busy_m), 0);
    endtask

    task automatic load_c_tables();
        int exp_c [9];
        exp_c = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
        for (int i = 0; i < 9; i++) begin
            pix_buf[i] = 1;
            exp_buf[i] = exp_c[i];
        end
    endtask

    task automatic load_b_tables();
        for (int i = 0; i < 16; i++) pix_buf[i] = i + 1;
        exp_buf[0] = 14;
        exp_buf[1] = 22;
        exp_buf[2] = 46;
        exp_buf[3] = 54;
    endtask

    initial begin
        int hs, cyc;
        checks    = 0;
        errors    = 0;
        sel       = 0;
        rst       = 1'b1;
        wgt_data  = '0;
        wgt_addr  = '0;
        bias_data = '0;
        bias_addr = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        start_v   = '0;
        wgt_we_v  = '0;
        bias_we_v = '0;

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check_val($sformatf("rst_busy%0d", s), int'(busy_v[s]), 0);
            check_val($sformatf("rst_done%0d", s), int'(done_v[s]), 0);
            check_val($sformatf("rst_in_ready%0d", s), int'(in_ready_v[s]), 0);
            check_val($sformatf("rst_out_valid%0d", s), int'(out_valid_v[s]), 0);
            check_val($sformatf("rst_out_data%0d", s), int'(out_data_v[s]), 0);
        end
        rst = 1'b0;

        // 1x1, w=2, bias=5, all pixels 3 -> 11
        write_wgt(0, 0, 2);
        write_bias(0, 5);
        for (int i = 0; i < 16; i++) begin
            pix_buf[i] = 3;
            exp_buf[i] = 11;
        end
        run_frame(0, 16, 16, 1'b0, "t1x1");

        // 2x2 ones, stride 2, input 1..16
        for (int i = 0; i < 4; i++) write_wgt(1, i, 1);
        write_bias(1, 0);
        load_b_tables();
        run_frame(1, 16, 4, 1'b0, "t2x2");

        // 3x3 ones, pad 1, input all 1
        for (int i = 0; i < 9; i++) write_wgt(2, i, 1);
        write_bias(2, 0);
        load_c_tables();
        run_frame(2, 9, 9, 1'b0, "tpad");

        // saturation: w=100 on +/-100 pixels
        write_wgt(0, 0, 100);
        write_bias(0, 0);
        for (int i = 0; i < 16; i++) begin
            pix_buf[i] = (i % 2 == 0) ? 100 : -100;
`ifdef CONV2D_STREAM_RELU_EN
            exp_buf[i] = (i % 2 == 0) ? 127 : 0;
`else
            exp_buf[i] = (i % 2 == 0) ? 127 : -128;
`endif
        end
        run_frame(0, 16, 16, 1'b0, "tsat");

        // gapped input and throttled output give the same sequence
        load_b_tables();
        run_frame(1, 16, 4, 1'b1, "tgap");

        // reset during MAC of output 2, then a full frame on retained weights
        load_c_tables();
        start_frame(2);
        feed(9, 1'b0, "trst");
        hs = 0;
        cyc = 0;
        out_ready = 1'b1;
        while (hs < 2 && cyc < 200) begin
            if (out_valid_m) hs++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check_val("trst_accepted", hs, 2);
        @(negedge clk);
        check_val("trst_busy_before", int'(busy_m), 1);
        check_val("trst_valid_before", int'(out_valid_m), 0);
        rst = 1'b1;
        #1;
        check_val("trst_busy", int'(busy_m), 0);
        check_val("trst_out_valid", int'(out_valid_m), 0);
        check_val("trst_out_data", int'(out_data_m), 0);
        check_val("trst_in_ready", int'(in_ready_m), 0);
        check_val("trst_done", int'(done_m), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("trst_no_output", int'(out_valid_m), 0);
        run_frame(2, 9, 9, 1'b0, "tpost");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv2d_stream.md
Name: conv2d_stream

Overview:
Sequential, parametrised 2-D convolution engine and the clocked successor to the combinational conv2d.
- Buffers one multi-channel input frame from a valid/ready stream.
- Computes each output element with one multiply-accumulate (MAC) per cycle, summing across all input channels and adding a per-output-channel bias.
- Right-shifts the sum by frac_bits, saturates it, and emits it on a valid/ready stream.
- Sits between feature-map producers and the next layer in the inference pipeline.

Parameters:
in_channels, 1, input feature channels
out_channels, 1, output feature channels
kernel_rows, 3, kernel height
kernel_cols, 3, kernel width
stride_row, 1, vertical stride
stride_col, 1, horizontal stride
pad_rows, 0, zero rows added above and below
pad_cols, 0, zero cols added left and right
rows, 27, input height
cols, 27, input width
data_size, 8, signed width of pixels, weights, biases and outputs
acc_size, 32, signed accumulator width
frac_bits, 0, arithmetic right shift applied before saturation

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wgt_we  in  1  weight write strobe
wgt_addr  in  clog2(out_channels*in_channels*kernel_rows*kernel_cols)  index ((co*in_channels+ci)*kernel_rows+kr)*kernel_cols+kc
wgt_data  in  data_size  signed weight
bias_we  in  1  bias write strobe
bias_addr  in  clog2(out_channels) (min 1)  output channel
bias_data  in  data_size  signed bias
start  in  1  begin frame
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after the last output is accepted
in_valid  in  1  pixel valid
in_ready  out  1  high only in LOAD
in_data  in  data_size  pixel, order ci-major, then row, then col
out_valid  out  1  output valid
out_ready  in  1  consumer ready
out_data  out  data_size  result, order co-major, then out row, then out col

Behaviour:
- Output dimensions: out_rows = (rows+2*pad_rows-kernel_rows)/stride_row+1; out_cols likewise. The operation is cross-correlation; the kernel is not flipped.
- Reset (async, any state): FSM goes to IDLE; busy, done, in_ready, out_valid and out_data are 0; all counters are 0. Weight and bias memories are not cleared.
- IDLE:
  - wgt_we / bias_we write memory in the same cycle.
  - A start pulse moves the FSM to LOAD on the next cycle.
  - Writes while busy are ignored.
- LOAD:
  - in_ready=1. A pixel is stored on each in_valid&in_ready cycle.
  - After in_channels*rows*cols beats the FSM moves to MAC; the pixel count wraps to 0.
  - start is ignored while busy.
- MAC:
  - On entry, acc = sign-extended bias shifted left by frac_bits.
  - Each cycle adds one product x*w. The product is 2*data_size signed, sign-extended to acc_size.
  - x=0 when the padded coordinate falls outside the input.
  - The loop runs exactly in_channels*kernel_rows*kernel_cols cycles.
- FIN (1 cycle):
  - res = acc >>> frac_bits, saturated to [-2^(data_size-1), 2^(data_size-1)-1].
  - res is registered into out_data; out_valid=1; the FSM moves to EMIT.
- EMIT:
  - out_data and out_valid stay stable until out_ready.
  - On handshake, the FSM steps to the next (co,row,col) and returns to MAC.
  - After the last element, the FSM goes to IDLE and done pulses for 1 cycle.
- Latency per output: K=in_channels*kernel_rows*kernel_cols MAC cycles + 1 FIN cycle + at least 1 EMIT cycle.
- Accumulator overflow beyond acc_size wraps; saturation applies only at FIN.
- Reset mid-frame discards the frame; no partial output is emitted afterwards.

Optional Feature:
- Macro: CONV2D_STREAM_RELU_EN.
- Defined: after saturation, negative results become 0, so out_data is always >= 0.
- Undefined: signed saturated result passes unchanged.

Test Plan:
- 1x1 kernel, w=2, bias=5, 1 channel, 4x4 input all 3 -> 16 outputs of 11; done pulses once.
- 2x2 kernel all 1, stride 2, 4x4 input 1..16 row-major -> outputs 14, 22, 46, 54.
- 3x3 kernel all 1, pad 1, 3x3 input all 1 -> 4 6 4 / 6 9 6 / 4 6 4.
- data_size 8, 1x1 kernel, w=100, inputs 100 and -100 -> 127 and -128. With CONV2D_STREAM_RELU_EN: 127 and 0.
- out_ready toggled 1-of-3 cycles and in_valid gapped randomly -> identical output sequence; out_data stable while out_valid&!out_ready.
- rst asserted during MAC of output 2 -> all outputs 0 immediately. Next frame after start gives the correct full sequence using the retained weights.
